// File: rtl/bp_common_cfg_bus_pkg.sv
// Shared config-bus definitions: processor dimensions, register map, write record.
package bp_common_cfg_bus_pkg;

  localparam int cc_x_dim_gp = 2;
  localparam int cc_y_dim_gp = 2;
  localparam int num_core_gp = cc_x_dim_gp * cc_y_dim_gp;

  localparam int cfg_core_width_gp = 16;
  localparam int cfg_addr_width_gp = 16;
  localparam int cfg_data_width_gp = 64;

  localparam int cfg_regs_per_core_gp = 5;

  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_freeze_gp      = 16'h0001;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_core_id_gp     = 16'h0002;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_icache_mode_gp = 16'h0003;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_dcache_mode_gp = 16'h0004;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_cce_mode_gp    = 16'h0005;

  typedef struct packed {
    logic [cfg_core_width_gp-1:0] core;
    logic [cfg_addr_width_gp-1:0] addr;
    logic [cfg_data_width_gp-1:0] data;
  } bp_cfg_write_s;

  // Per-core register write order: freeze, core id, I$ mode, D$ mode, CCE mode.
  function automatic logic [cfg_addr_width_gp-1:0] cfg_reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return cfg_reg_freeze_gp;
      3'd1:    return cfg_reg_core_id_gp;
      3'd2:    return cfg_reg_icache_mode_gp;
      3'd3:    return cfg_reg_dcache_mode_gp;
      3'd4:    return cfg_reg_cce_mode_gp;
      default: return cfg_reg_freeze_gp;
    endcase
  endfunction

endpackage

// File: rtl/bp_cfg_seq_counter.sv
// Up/down counter of unacknowledged config writes; flags an ack with nothing outstanding.
module bsg_counter_up_down #(
  parameter  int max_val_p = 4,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up,
  input  logic                down,
  output logic [width_lp-1:0] count,
  output logic [width_lp-1:0] count_next,
  output logic                underflow
);

  localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

  // Next count: simultaneous up/down cancels; saturate at both ends.
  always_comb begin
    count_next = count;
    underflow  = 1'b0;
    if (up && !down) begin
      if (count != max_lp) count_next = count + width_lp'(1);
    end else if (down && !up) begin
      if (count == '0) underflow  = 1'b1;
      else             count_next = count - width_lp'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/bp_cfg_seq.sv
// Post-reset configuration sequencer: programs every core over the config bus,
// waits for all acks, then unfreezes the cores.
module bp_cfg_seq
  import bp_common_cfg_bus_pkg::*;
#(
  parameter int num_core_p        = num_core_gp,
  parameter int cfg_addr_width_p  = 16,
  parameter int cfg_data_width_p  = 64,
  parameter int max_outstanding_p = 4,
  localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        icache_mode_i,
  input  logic                        dcache_mode_i,
  input  logic                        cce_mode_i,
  output logic                        cfg_v_o,
  output logic [core_w_lp-1:0]        cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  input  logic                        cfg_ack_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o
);

  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
  localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_p - 1);
  localparam logic [cnt_w_lp-1:0]  max_cnt_lp   = cnt_w_lp'(max_outstanding_p);
  localparam logic [2:0]           last_reg_lp  = 3'(cfg_regs_per_core_gp - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DRAIN,
    UNFREEZE,
    FINAL,
    DONE
  } state_e;

  state_e               state, state_n;
  logic [core_w_lp-1:0] core_idx, core_n;
  logic [2:0]           reg_idx, reg_n;
  logic                 valid, valid_n;
  logic                 capture;
  logic                 icache_mode, dcache_mode, cce_mode;
  logic                 error;
  logic                 xfer;
  logic                 room;
  logic [cnt_w_lp-1:0]  count, count_next;
  logic                 underflow;

  assign xfer = valid & cfg_ready_i;
  // Valid for next cycle is decided from the post-update count so the
  // credit limit is never exceeded; valid itself stays registered.
  assign room = (count_next < max_cnt_lp);

  bsg_counter_up_down #(
    .max_val_p(max_outstanding_p)
  ) outstanding (
    .clk       (clk_i),
    .rst       (reset_i),
    .up        (xfer),
    .down      (cfg_ack_i),
    .count     (count),
    .count_next(count_next),
    .underflow (underflow)
  );

  // Next-state and index sequencing; a raised valid is held until it transfers.
  always_comb begin
    state_n = state;
    core_n  = core_idx;
    reg_n   = reg_idx;
    valid_n = valid;
    capture = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_n = SETUP;
          core_n  = '0;
          reg_n   = '0;
          valid_n = room;
          capture = 1'b1;
        end
      end
      SETUP: begin
        if (!valid) begin
          valid_n = room;
        end else if (xfer) begin
          valid_n = room;
          if (reg_idx == last_reg_lp) begin
            reg_n = '0;
            if (core_idx == last_core_lp) begin
              state_n = DRAIN;
              valid_n = 1'b0;
            end else begin
              core_n = core_idx + core_w_lp'(1);
            end
          end else begin
            reg_n = reg_idx + 3'd1;
          end
        end
      end
      DRAIN: begin
        if (count == '0) begin
          state_n = UNFREEZE;
          core_n  = '0;
          reg_n   = '0;
          valid_n = room;
        end
      end
      UNFREEZE: begin
        if (!valid) begin
          valid_n = room;
        end else if (xfer) begin
          valid_n = room;
          if (core_idx == last_core_lp) begin
            state_n = FINAL;
            valid_n = 1'b0;
          end else begin
            core_n = core_idx + core_w_lp'(1);
          end
        end
      end
      FINAL: begin
        if (count == '0) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  // Indices, valid, captured modes and sticky error.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      core_idx    <= '0;
      reg_idx     <= '0;
      valid       <= 1'b0;
      icache_mode <= 1'b0;
      dcache_mode <= 1'b0;
      cce_mode    <= 1'b0;
      error       <= 1'b0;
    end else begin
      core_idx <= core_n;
      reg_idx  <= reg_n;
      valid    <= valid_n;
      error    <= error | underflow;
      if (capture) begin
        icache_mode <= icache_mode_i;
        dcache_mode <= dcache_mode_i;
        cce_mode    <= cce_mode_i;
      end
    end
  end

  // Payload decode from registered indices; zero whenever no write is offered.
  always_comb begin
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    if (valid) begin
      cfg_core_o = core_idx;
      if (state == UNFREEZE) begin
        cfg_addr_o = cfg_addr_width_p'(cfg_reg_freeze_gp);
      end else begin
        cfg_addr_o = cfg_addr_width_p'(cfg_reg_addr(reg_idx));
        case (reg_idx)
          3'd0:    cfg_data_o = cfg_data_width_p'(1);
          3'd1:    cfg_data_o = cfg_data_width_p'(core_idx);
          3'd2:    cfg_data_o = cfg_data_width_p'(icache_mode);
          3'd3:    cfg_data_o = cfg_data_width_p'(dcache_mode);
          3'd4:    cfg_data_o = cfg_data_width_p'(cce_mode);
          default: cfg_data_o = '0;
        endcase
      end
    end
  end

  assign cfg_v_o = valid;
  assign busy_o  = (state != IDLE) && (state != DONE);
  assign done_o  = (state == DONE);
  assign error_o = error;

endmodule

// File: tb/tb_bp_cfg_seq.sv
// Self-checking bench for bp_cfg_seq: expected write lists built from the register
// map, a credit/ack model, and directed plus randomized ready/ack patterns.
module tb_bp_cfg_seq;
  import bp_common_cfg_bus_pkg::*;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, icm, dcm, ccm;
  logic          cfg_v;
  logic [CW-1:0] cfg_core;
  logic [15:0]   cfg_addr;
  logic [63:0]   cfg_data;
  logic          cfg_ready, cfg_ack;
  logic          busy, done, error;

  always #5 clk = ~clk;

  bp_cfg_seq #(
    .num_core_p       (N),
    .cfg_addr_width_p (16),
    .cfg_data_width_p (64),
    .max_outstanding_p(MAXO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .start_i      (start),
    .icache_mode_i(icm),
    .dcache_mode_i(dcm),
    .cce_mode_i   (ccm),
    .cfg_v_o      (cfg_v),
    .cfg_core_o   (cfg_core),
    .cfg_addr_o   (cfg_addr),
    .cfg_data_o   (cfg_data),
    .cfg_ready_i  (cfg_ready),
    .cfg_ack_i    (cfg_ack),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int steps = 0, n_run = 0, out = 0, n_acks = 0, zero_step = -1;
  int rdy_pol = 0, ack_pol = 0, ack_dly = 1, took = 0, guard = 0;
  bit merr = 0, m_busy = 0, hold_v = 0, ack_once = 0, drain_chk = 0, ack_rand = 0;
  bp_cfg_write_s hold_w;
  bp_cfg_write_s exp_q[$];
  int due_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write list: five setup writes per core, then one unfreeze per core.
  task automatic build(input logic ic, input logic dc, input logic cc);
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      exp_q.push_back('{core: 16'(c), addr: cfg_reg_freeze_gp,      data: 64'd1});
      exp_q.push_back('{core: 16'(c), addr: cfg_reg_core_id_gp,     data: 64'(c)});
      exp_q.push_back('{core: 16'(c), addr: cfg_reg_icache_mode_gp, data: 64'(ic)});
      exp_q.push_back('{core: 16'(c), addr: cfg_reg_dcache_mode_gp, data: 64'(dc)});
      exp_q.push_back('{core: 16'(c), addr: cfg_reg_cce_mode_gp,    data: 64'(cc)});
    end
    for (int c = 0; c < N; c++)
      exp_q.push_back('{core: 16'(c), addr: cfg_reg_freeze_gp, data: 64'd0});
  endtask

  // One clock: sample at negedge, check, then drive ready/ack for the next posedge.
  task automatic step();
    logic rdy, ack, xfer;
    bp_cfg_write_s e;
    @(negedge clk);
    steps++;
    if (hold_v) begin
      check("hold_valid", 64'(cfg_v), 64'd1);
      check("hold_core", 64'(cfg_core), 64'(hold_w.core));
      check("hold_addr", 64'(cfg_addr), 64'(hold_w.addr));
      check("hold_data", cfg_data, hold_w.data);
    end
    check("error_flag", 64'(error), 64'(merr));
    case (rdy_pol)
      0:       rdy = 1'b1;
      1:       rdy = ~cfg_ready;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    xfer = cfg_v && rdy;
    ack = 1'b0;
    case (ack_pol)
      1: ack = xfer;
      2: if (due_q.size() > 0 && due_q[0] <= steps) begin
           ack = 1'b1;
           void'(due_q.pop_front());
         end
      3: ack = ((out > 0) || xfer) && ($urandom_range(0, 1) == 1);
      default: ack = 1'b0;
    endcase
    if (ack_once) begin
      ack = 1'b1;
      ack_once = 1'b0;
    end
    cfg_ready = rdy;
    cfg_ack   = ack;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("extra_write", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        if (drain_chk && e.addr == cfg_reg_freeze_gp && e.data == 64'd0 && e.core == 16'd0) begin
          check("unfreeze_gap", 64'(steps - zero_step), 64'd2);
          check("unfreeze_acks", 64'(n_acks), 64'(5 * N));
        end
        check("w_core", 64'(cfg_core), 64'(e.core));
        check("w_addr", 64'(cfg_addr), 64'(e.addr));
        check("w_data", cfg_data, e.data);
      end
      n_run++;
      if (ack_pol == 2) due_q.push_back(steps + (ack_rand ? int'($urandom_range(1, 6)) : ack_dly));
    end
    if (xfer && ack) begin
    end else if (xfer) begin
      out++;
    end else if (ack) begin
      if (out == 0) merr = 1'b1;
      else          out--;
    end
    if (ack) n_acks++;
    if (n_run == 5 * N && out == 0 && zero_step < 0) zero_step = steps;
    check("credit_bound", 64'(out <= MAXO), 64'd1);
    hold_v = cfg_v && !rdy;
    hold_w = '{core: 16'(cfg_core), addr: cfg_addr, data: cfg_data};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_v"},     64'(cfg_v),    64'd0);
    check({tag, "_busy"},  64'(busy),     64'd0);
    check({tag, "_done"},  64'(done),     64'd0);
    check({tag, "_error"}, 64'(error),    64'd0);
    check({tag, "_core"},  64'(cfg_core), 64'd0);
    check({tag, "_addr"},  64'(cfg_addr), 64'd0);
    check({tag, "_data"},  cfg_data,      64'd0);
  endtask

  task automatic do_reset(input int dly);
    #(dly);
    rst = 1'b1;
    cfg_ack = 1'b0; cfg_ready = 1'b0; start = 1'b0;
    exp_q.delete(); due_q.delete();
    out = 0; merr = 1'b0; m_busy = 1'b0; hold_v = 1'b0; ack_once = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic ic, input logic dc, input logic cc);
    bit accepted;
    accepted = !m_busy;
    icm = ic; dcm = dc; ccm = cc;
    start = 1'b1;
    if (accepted) begin
      build(ic, dc, cc);
      m_busy = 1'b1; n_run = 0; n_acks = 0; zero_step = -1;
    end
    step();
    start = 1'b0;
    if (accepted) check("start_valid", 64'(cfg_v), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    icm = 1'($urandom_range(0, 1));
    dcm = 1'($urandom_range(0, 1));
    ccm = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget, output int t);
    t = 0;
    while (done !== 1'b1 && t < budget) begin
      step();
      t++;
    end
    check("done_reached", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("writes_total", 64'(n_run), 64'(6 * N));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("error_at_done", 64'(error), 64'(merr));
    m_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; icm = 1'b0; dcm = 1'b0; ccm = 1'b0;
    cfg_ready = 1'b0; cfg_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    // Ack with nothing outstanding sets the sticky error.
    ack_once = 1'b1;
    step();
    step();
    check("idle_ack_error", 64'(error), 64'd1);
    do_reset(2);

    // Basic run: ready high, ack one cycle after each transfer.
    rdy_pol = 0; ack_pol = 2; ack_dly = 1; ack_rand = 1'b0;
    do_start(1'b1, 1'b0, 1'b1);
    wait_done(200, took);

    // Minimum latency with same-cycle acks; restart from DONE.
    ack_pol = 1;
    do_start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_done(200, took);
    check("min_latency", 64'(took + 1), 64'(6 * N + 3));

    // Credit limit: no acks, then a single ack.
    ack_pol = 0;
    do_start(1'b1, 1'b1, 1'b0);
    repeat (8) step();
    check("credit_writes", 64'(n_run), 64'(MAXO));
    check("credit_stall", 64'(cfg_v), 64'd0);
    ack_once = 1'b1;
    repeat (6) step();
    check("credit_one_more", 64'(n_run), 64'(MAXO + 1));
    check("credit_stall2", 64'(cfg_v), 64'd0);
    ack_pol = 3;
    wait_done(2000, took);

    // Backpressure with toggling ready; a start during SETUP is ignored.
    rdy_pol = 1; ack_pol = 2; ack_rand = 1'b1;
    do_start(1'b0, 1'b1, 1'b1);
    repeat (4) step();
    do_start(1'b1, 1'b0, 1'b0);
    wait_done(2000, took);

    // Drain: acks delayed ten cycles.
    rdy_pol = 0; ack_pol = 2; ack_rand = 1'b0; ack_dly = 10; drain_chk = 1'b1;
    do_start(1'b1, 1'b1, 1'b1);
    wait_done(2000, took);
    drain_chk = 1'b0;

    // Randomized ready and acks.
    for (int r = 0; r < 4; r++) begin
      rdy_pol = 2; ack_pol = 3;
      do_start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(3000, took);
    end

    // Reset after the third transfer, then a full fresh sequence.
    rdy_pol = 0; ack_pol = 2; ack_rand = 1'b0; ack_dly = 1;
    do_start(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (n_run < 3 && guard < 50) begin
      step();
      guard++;
    end
    check("third_transfer", 64'(n_run), 64'd3);
    do_reset(7);
    step();
    check_all_zero("post_reset");
    do_start(1'b0, 1'b0, 1'b1);
    wait_done(300, took);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
